// File: rtl/mc_if.sv
// Controller bus interface: run/instruction/flag/memory-ready inputs plus
// all datapath control strobes and status outputs.
//   slave  : controller side (mc_controller)
//   master : driver side (datapath / testbench)
interface mc_if;
  logic        run;
  logic [15:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_we;
  logic        pc_src;
  logic        ir_we;
  logic        reg_src;
  logic        reg_write;
  logic [1:0]  alu_ctrl;
  logic        alu_src_imm;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic [3:0]  flags;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;

  modport slave (
    input  run, instr, alu_flags, mem_ready,
    output pc_we, pc_src, ir_we, reg_src, reg_write, alu_ctrl, alu_src_imm,
           mem_read, mem_write, mem_to_reg, flags, state, halted, illegal
  );

  modport master (
    output run, instr, alu_flags, mem_ready,
    input  pc_we, pc_src, ir_we, reg_src, reg_write, alu_ctrl, alu_src_imm,
           mem_read, mem_write, mem_to_reg, flags, state, halted, illegal
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle CPU control FSM (Moore).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - mc_if.slave: run, instr, alu_flags, mem_ready in;
//            PC/IR/regfile/ALU/memory strobes, latched flags, state,
//            halted and illegal out.
// All outputs decode from r_state/r_opcode/r_flags only, so reset clears
// them combinationally without waiting for a clock edge.
module mc_controller (
  input  logic clk,
  input  logic rst_n,
  mc_if.slave  bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [3:0] OP_LDR  = 4'h4;
  localparam logic [3:0] OP_STR  = 4'h5;
  localparam logic [3:0] OP_B    = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [3:0] r_opcode;
  logic [3:0] r_flags;

  logic w_is_alu, w_is_ldr, w_is_str, w_is_b, w_is_beq, w_is_bne;
  logic w_is_branch, w_is_halt, w_is_illegal, w_taken;
  logic w_unused_instr;

  // Only the opcode nibble is consumed here; the rest feeds the datapath.
  assign w_unused_instr = ^bus.instr[11:0];

  assign w_is_alu     = (r_opcode[3:2] == 2'b00);
  assign w_is_ldr     = (r_opcode == OP_LDR);
  assign w_is_str     = (r_opcode == OP_STR);
  assign w_is_b       = (r_opcode == OP_B);
  assign w_is_beq     = (r_opcode == OP_BEQ);
  assign w_is_bne     = (r_opcode == OP_BNE);
  assign w_is_branch  = w_is_b | w_is_beq | w_is_bne;
  assign w_is_halt    = (r_opcode == OP_HALT);
  assign w_is_illegal = ~(w_is_alu | w_is_ldr | w_is_str | w_is_branch | w_is_halt);
  // Z is flags[2]; uses the value latched by an earlier ALU instruction.
  assign w_taken      = w_is_b | (w_is_beq & r_flags[2]) | (w_is_bne & ~r_flags[2]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = bus.run ? ST_FETCH : ST_IDLE;
      // run=0 still completes this fetch, then parks in IDLE.
      ST_FETCH:  w_next = bus.run ? ST_DECODE : ST_IDLE;
      ST_DECODE: w_next = (w_is_halt | w_is_illegal) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (w_is_alu)                   w_next = ST_WB;
        else if (w_is_ldr | w_is_str)   w_next = ST_MEM;
        else                            w_next = ST_FETCH;
      end
      ST_MEM: begin
        if (bus.mem_ready) w_next = w_is_ldr ? ST_WB : ST_FETCH;
        else               w_next = ST_MEM;
      end
      ST_WB:     w_next = ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;  // code 7 recovers
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_opcode <= 4'h0;
      r_flags  <= 4'h0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH)
        r_opcode <= bus.instr[15:12];
      if ((r_state == ST_EXEC) && w_is_alu)
        r_flags <= bus.alu_flags;
    end
  end

  logic       w_pc_we, w_pc_src, w_ir_we, w_reg_src, w_reg_write;
  logic [1:0] w_alu_ctrl;
  logic       w_alu_src_imm, w_mem_read, w_mem_write, w_mem_to_reg;

  always_comb begin
    w_pc_we       = 1'b0;
    w_pc_src      = 1'b0;
    w_ir_we       = 1'b0;
    w_reg_src     = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_ctrl    = 2'b00;
    w_alu_src_imm = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_to_reg  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ir_we = 1'b1;
        w_pc_we = 1'b1;
      end
      // STR and compare-branches need rd on port A.
      ST_DECODE: w_reg_src = w_is_str | w_is_beq | w_is_bne;
      ST_EXEC: begin
        if (w_is_alu) w_alu_ctrl = r_opcode[1:0];
        if (w_is_ldr | w_is_str) w_alu_src_imm = 1'b1;
        if (w_is_branch & w_taken) begin
          w_pc_we  = 1'b1;
          w_pc_src = 1'b1;
        end
      end
      // Address computation (base + imm) stays stable for the whole access.
      ST_MEM: begin
        w_alu_src_imm = 1'b1;
        w_mem_read    = w_is_ldr;
        w_mem_write   = w_is_str;
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_is_ldr;
      end
      default: ;
    endcase
  end

  assign bus.pc_we       = w_pc_we;
  assign bus.pc_src      = w_pc_src;
  assign bus.ir_we       = w_ir_we;
  assign bus.reg_src     = w_reg_src;
  assign bus.reg_write   = w_reg_write;
  assign bus.alu_ctrl    = w_alu_ctrl;
  assign bus.alu_src_imm = w_alu_src_imm;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.flags       = r_flags;
  assign bus.state       = r_state;
  assign bus.halted      = (r_state == ST_HALT);
  // Flag the bad opcode from decode onward while it is held in the HALT state.
  assign bus.illegal     = ((r_state == ST_DECODE) || (r_state == ST_HALT)) & w_is_illegal;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic clk;
  logic rst_n;
  mc_if bus_if ();

  mc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] m_flags;   // reference copy of the latched flags

  typedef struct {
    logic [15:0] ins;
    int          waits;
    logic [3:0]  af;
    int          lat;
    int          nmem;
    int          nrw;
    int          nm2r;
    int          ntk;
    logic [3:0]  flg;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {pc_we, pc_src, ir_we, reg_src, reg_write, alu_ctrl, alu_src_imm,
  //  mem_read, mem_write, mem_to_reg, halted, illegal}
  function automatic logic [12:0] dut_outs();
    return {bus_if.pc_we, bus_if.pc_src, bus_if.ir_we, bus_if.reg_src,
            bus_if.reg_write, bus_if.alu_ctrl, bus_if.alu_src_imm,
            bus_if.mem_read, bus_if.mem_write, bus_if.mem_to_reg,
            bus_if.halted, bus_if.illegal};
  endfunction

  // Expected control outputs for one cycle of an instruction, from the
  // per-phase rules of the instruction set.
  function automatic logic [12:0] exp_outs(input int s, input logic [3:0] op, input logic [3:0] f);
    logic pw, ps, iw, rs, rw, asi, mr, mwr, m2r, hl, il;
    logic [1:0] ac;
    logic taken;
    {pw, ps, iw, rs, rw, asi, mr, mwr, m2r, hl, il} = '0;
    ac = 2'b00;
    taken = (op == 4'h6) || (op == 4'h7 && f[2]) || (op == 4'h8 && !f[2]);
    if (s == 1) begin iw = 1; pw = 1; end
    if (s == 2) rs = (op == 4'h5 || op == 4'h7 || op == 4'h8);
    if (s == 3) begin
      if (op < 4'h4) ac = op[1:0];
      if (op == 4'h4 || op == 4'h5) asi = 1;
      if (taken) begin pw = 1; ps = 1; end
    end
    if (s == 4) begin asi = 1; mr = (op == 4'h4); mwr = (op == 4'h5); end
    if (s == 5) begin rw = 1; m2r = (op == 4'h4); end
    return {pw, ps, iw, rs, rw, ac, asi, mr, mwr, m2r, hl, il};
  endfunction

  // Entry: at a negedge with the DUT in FETCH. Builds the expected state
  // trace from the instruction class and compares cycle by cycle.
  task automatic run_model(input logic [15:0] ins, input int waits, input logic [3:0] af);
    int q[$];
    logic [3:0] op;
    op = ins[15:12];
    bus_if.instr = ins;
    bus_if.alu_flags = af;
    q.push_back(1);
    q.push_back(2);
    q.push_back(3);
    if (op < 4'h4) q.push_back(5);
    else if (op == 4'h4 || op == 4'h5) begin
      repeat (waits + 1) q.push_back(4);
      if (op == 4'h4) q.push_back(5);
    end
    foreach (q[i]) begin
      chk("model_state", 32'(bus_if.state), 32'(q[i]));
      chk("model_outs", 32'(dut_outs()), 32'(exp_outs(q[i], op, m_flags)));
      chk("model_flags", 32'(bus_if.flags), 32'(m_flags));
      if (q[i] == 4) bus_if.mem_ready = (i + 1 >= q.size()) || (q[i+1] != 4);
      else bus_if.mem_ready = 1'b0;
      if (q[i] == 3 && op < 4'h4) m_flags = af;
      @(negedge clk);
    end
    bus_if.mem_ready = 1'b0;
  endtask

  // Entry: at a negedge with the DUT in FETCH. Observes the DUT until the
  // next FETCH and tallies strobe activity (no reference model involved).
  task automatic measure(input logic [15:0] ins, input int waits, input logic [3:0] af,
                         output int lat, output int nmem, output int nrw,
                         output int nm2r, output int ntk);
    int mcnt;
    lat = 0; nmem = 0; nrw = 0; nm2r = 0; ntk = 0; mcnt = 0;
    bus_if.instr = ins;
    bus_if.alu_flags = af;
    do begin
      if (bus_if.mem_read | bus_if.mem_write) nmem++;
      if (bus_if.reg_write) nrw++;
      if (bus_if.reg_write & bus_if.mem_to_reg) nm2r++;
      if (bus_if.pc_we & bus_if.pc_src) ntk++;
      if (bus_if.state == 3'd4) begin
        bus_if.mem_ready = (mcnt == waits);
        mcnt++;
      end else bus_if.mem_ready = 1'b0;
      lat++;
      @(negedge clk);
    end while (bus_if.state != 3'd1 && lat < 60);
    bus_if.mem_ready = 1'b0;
  endtask

  // Asserts reset mid-cycle, checks immediate clearing, releases it and
  // waits for the restart into FETCH (run is held at 1).
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(bus_if.state), 32'd0);
    chk({tag, "_outs"},  32'(dut_outs()), 32'd0);
    chk({tag, "_flags"}, 32'(bus_if.flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk({tag, "_hold"}, 32'(bus_if.state), 32'd0);
    @(negedge clk);
    chk({tag, "_restart"}, 32'(bus_if.state), 32'd1);
    m_flags = 4'h0;
  endtask

  task automatic halt_seq(input logic [15:0] ins, input logic exp_ill, input string tag);
    bus_if.instr = ins;
    @(negedge clk);
    chk({tag, "_decode"}, 32'(bus_if.state), 32'd2);
    @(negedge clk);
    chk({tag, "_state"},   32'(bus_if.state), 32'd6);
    chk({tag, "_illegal"}, 32'(bus_if.illegal), 32'(exp_ill));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk({tag, "_stay"}, 32'(bus_if.state), 32'd6);
      chk({tag, "_outs"}, 32'(dut_outs()), 32'({11'b0, 1'b1, exp_ill}));
    end
  endtask

  initial begin
    int lat, nmem, nrw, nm2r, ntk;
    logic [3:0] op;

    tbl[0]  = '{16'h0000, 0, 4'b0100, 4, 0, 1, 0, 0, 4'b0100};
    tbl[1]  = '{16'h7000, 0, 4'b0000, 3, 0, 0, 0, 1, 4'b0100};
    tbl[2]  = '{16'h8000, 0, 4'b0000, 3, 0, 0, 0, 0, 4'b0100};
    tbl[3]  = '{16'h4123, 3, 4'b1111, 8, 4, 1, 1, 0, 4'b0100};
    tbl[4]  = '{16'h5abc, 0, 4'b0000, 4, 1, 0, 0, 0, 4'b0100};
    tbl[5]  = '{16'h1000, 0, 4'b0000, 4, 0, 1, 0, 0, 4'b0000};
    tbl[6]  = '{16'h8123, 0, 4'b0100, 3, 0, 0, 0, 1, 4'b0000};
    tbl[7]  = '{16'h7fff, 0, 4'b0100, 3, 0, 0, 0, 0, 4'b0000};
    tbl[8]  = '{16'h6000, 0, 4'b1111, 3, 0, 0, 0, 1, 4'b0000};
    tbl[9]  = '{16'h3fff, 0, 4'b1011, 4, 0, 1, 0, 0, 4'b1011};
    tbl[10] = '{16'h4000, 0, 4'b0000, 5, 1, 1, 1, 0, 4'b1011};
    tbl[11] = '{16'h5fff, 2, 4'b0100, 6, 3, 0, 0, 0, 4'b1011};

    rst_n = 1'b0;
    bus_if.run = 1'b0;
    bus_if.instr = 16'h0;
    bus_if.alu_flags = 4'h0;
    bus_if.mem_ready = 1'b0;
    m_flags = 4'h0;
    #1;
    chk("reset_state", 32'(bus_if.state), 32'd0);
    chk("reset_outs",  32'(dut_outs()), 32'd0);
    chk("reset_flags", 32'(bus_if.flags), 32'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_run0", 32'(bus_if.state), 32'd0);
    @(negedge clk);
    chk("idle_run0_b", 32'(bus_if.state), 32'd0);
    bus_if.run = 1'b1;
    @(negedge clk);
    chk("idle_to_fetch", 32'(bus_if.state), 32'd1);

    // ADD with flags 0100: states 1,2,3,5 then back to 1.
    run_model(16'h0000, 0, 4'b0100);
    chk("add_flags", 32'(bus_if.flags), 32'b0100);
    chk("add_next_fetch", 32'(bus_if.state), 32'd1);

    for (int i = 0; i < 12; i++) begin
      measure(tbl[i].ins, tbl[i].waits, tbl[i].af, lat, nmem, nrw, nm2r, ntk);
      chk($sformatf("tbl%0d_lat", i),   32'(lat),  32'(tbl[i].lat));
      chk($sformatf("tbl%0d_mem", i),   32'(nmem), 32'(tbl[i].nmem));
      chk($sformatf("tbl%0d_rw", i),    32'(nrw),  32'(tbl[i].nrw));
      chk($sformatf("tbl%0d_m2r", i),   32'(nm2r), 32'(tbl[i].nm2r));
      chk($sformatf("tbl%0d_taken", i), 32'(ntk),  32'(tbl[i].ntk));
      chk($sformatf("tbl%0d_flags", i), 32'(bus_if.flags), 32'(tbl[i].flg));
    end
    m_flags = tbl[11].flg;

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 8));
      run_model({op, 12'($urandom)}, int'($urandom_range(0, 4)), 4'($urandom));
    end

    // run=0 sampled in FETCH finishes the fetch and returns to IDLE.
    bus_if.instr = 16'h1000;
    bus_if.run = 1'b0;
    @(negedge clk);
    chk("run0_fetch_idle", 32'(bus_if.state), 32'd0);
    @(negedge clk);
    chk("run0_stay_idle", 32'(bus_if.state), 32'd0);
    bus_if.run = 1'b1;
    @(negedge clk);
    chk("run1_refetch", 32'(bus_if.state), 32'd1);

    // Reset mid-MEM of an LDR waiting on memory.
    bus_if.instr = 16'h4000;
    bus_if.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("mem_reached", 32'(bus_if.state), 32'd4);
    chk("mem_read_on", 32'(bus_if.mem_read), 32'd1);
    async_reset("rst_mem");

    // Reset during WB of an ALU op whose flags have just loaded.
    bus_if.instr = 16'h2000;
    bus_if.alu_flags = 4'b1111;
    repeat (3) @(negedge clk);
    chk("wb_reached", 32'(bus_if.state), 32'd5);
    chk("wb_flags", 32'(bus_if.flags), 32'hF);
    async_reset("rst_wb");

    run_model(16'h0000, 0, 4'b0011);
    chk("post_rst_flags", 32'(bus_if.flags), 32'b0011);

    halt_seq(16'hA000, 1'b1, "illegal_op");
    @(negedge clk);
    async_reset("rst_halt");
    halt_seq(16'hF000, 1'b0, "halt_op");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
